// File: rtl/lcd_capture_funcmod.sv
// Captures a fixed window of an incoming RGB666 LCD stream into a 128-wide
// RGB565 frame buffer, one complete frame per iCall request.
module lcd_capture_funcmod #(
    parameter logic [10:0] SA    = 11'd48,
    parameter logic [10:0] SB    = 11'd40,
    parameter logic [9:0]  SO    = 10'd3,
    parameter logic [9:0]  SP    = 10'd29,
    parameter logic [7:0]  XSIZE = 8'd128,
    parameter logic [7:0]  YSIZE = 8'd96,
    parameter logic [9:0]  XOFF  = 10'd0,
    parameter logic [9:0]  YOFF  = 10'd0
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iCall,
    output logic        oDone,
    input  logic        iHSYNC,
    input  logic        iVSYNC,
    input  logic [5:0]  iRED,
    input  logic [5:0]  iGREEN,
    input  logic [5:0]  iBLUE,
    output logic [13:0] oAddr,
    output logic [15:0] oData,
    output logic        oWrEn
);

    localparam logic [11:0] H_START = 12'(SA) + 12'(SB) + 12'(XOFF);
    localparam logic [11:0] H_END   = H_START + 12'(XSIZE);
    localparam logic [10:0] V_START = 11'(SO) + 11'(SP) + 11'(YOFF);
    localparam logic [10:0] V_END   = V_START + 11'(YSIZE);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t      state;
    logic        hsync_s1, vsync_s1, hsync_prev, vsync_prev;
    logic [5:0]  red_s1, green_s1, blue_s1;
    logic [10:0] ch;
    logic [9:0]  cv;

    logic        h_edge, v_edge;
    logic [10:0] ch_next;
    logic [9:0]  cv_next;
    logic        in_window, last_pixel, capture_now;
    logic [7:0]  pix_x, pix_y;
    logic [13:0] pix_addr;
    logic [15:0] pix_data;
    logic        colour_lsb_unused;

    // ch_next/cv_next are the raster position of the pixel currently held in S1.
    always_comb begin
        h_edge  = hsync_prev & ~hsync_s1;
        v_edge  = vsync_prev & ~vsync_s1;
        ch_next = h_edge ? 11'd0 : ((ch == 11'h7FF) ? ch : ch + 11'd1);
        if (v_edge)
            cv_next = 10'd0;
        else if (h_edge)
            cv_next = (cv == 10'h3FF) ? cv : cv + 10'd1;
        else
            cv_next = cv;
    end

    always_comb begin
        in_window  = ({1'b0, ch_next} >= H_START) && ({1'b0, ch_next} < H_END) &&
                     ({1'b0, cv_next} >= V_START) && ({1'b0, cv_next} < V_END);
        pix_x      = 8'({1'b0, ch_next} - H_START);
        pix_y      = 8'({1'b0, cv_next} - V_START);
        pix_addr   = ({6'd0, pix_y} << 7) + {6'd0, pix_x};
        pix_data   = {red_s1[5:1], green_s1, blue_s1[5:1]};
        last_pixel = in_window && (pix_x == XSIZE - 8'd1) && (pix_y == YSIZE - 8'd1);
        // The V edge that arms a capture already belongs to the new frame.
        capture_now = (state == CAPTURE) || ((state == ARM) && v_edge);
        colour_lsb_unused = red_s1[0] ^ blue_s1[0];
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            hsync_s1   <= 1'b1;
            vsync_s1   <= 1'b1;
            hsync_prev <= 1'b1;
            vsync_prev <= 1'b1;
            red_s1     <= 6'd0;
            green_s1   <= 6'd0;
            blue_s1    <= 6'd0;
            ch         <= 11'd0;
            cv         <= 10'd0;
            oWrEn      <= 1'b0;
            oDone      <= 1'b0;
            oAddr      <= 14'd0;
            oData      <= 16'd0;
        end else begin
            hsync_s1   <= iHSYNC;
            vsync_s1   <= iVSYNC;
            hsync_prev <= hsync_s1;
            vsync_prev <= vsync_s1;
            red_s1     <= iRED;
            green_s1   <= iGREEN;
            blue_s1    <= iBLUE;
            ch         <= ch_next;
            cv         <= cv_next;
            oWrEn      <= 1'b0;
            oDone      <= 1'b0;

            case (state)
                IDLE:    if (iCall) state <= ARM;
                ARM:     if (v_edge) state <= CAPTURE;
                CAPTURE: state <= CAPTURE;
                DONE: begin
                    oDone <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A V edge mid-capture simply restarts addressing from the new frame.
            if (capture_now && in_window) begin
                oWrEn <= 1'b1;
                oAddr <= pix_addr;
                oData <= pix_data;
                if (last_pixel)
                    state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_lcd_capture_funcmod.sv
// Directed bench for lcd_capture_funcmod using a reduced raster so that
// several whole frames, restarts and resets fit in a short run.
module tb_lcd_capture_funcmod;

    localparam int SA = 6, SB = 4, SO = 2, SP = 3;
    localparam int XS = 8, YS = 4, XOFF = 1, YOFF = 1;
    localparam int SE = 24, SS = 12;
    localparam int HS = SA + SB + XOFF;
    localparam int VS = SO + SP + YOFF;
    localparam int FRAME = SE * SS;
    localparam logic [13:0] FINAL_ADDR = 14'd391;

    logic        CLOCK, RESET, iCall, oDone, iHSYNC, iVSYNC, oWrEn;
    logic [5:0]  iRED, iGREEN, iBLUE;
    logic [13:0] oAddr;
    logic [15:0] oData;

    int vectors = 0;
    int miscompares = 0;

    int gh = 0, gv = 0;
    bit stall = 0;

    bit          d1_in = 0, d2_in = 0;
    logic [13:0] d1_addr = '0, d2_addr = '0;
    logic [15:0] d1_data = '0, d2_data = '0;
    logic [13:0] hold_addr = '0;
    logic [15:0] hold_data = '0;
    bit          prev_final = 0;

    int          writes_seen, done_seen;
    logic [13:0] first_addr, last_addr;
    logic [15:0] data_a0, data_a1;

    lcd_capture_funcmod #(
        .SA(11'd6), .SB(11'd4), .SO(10'd2), .SP(10'd3),
        .XSIZE(8'd8), .YSIZE(8'd4), .XOFF(10'd1), .YOFF(10'd1)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iCall(iCall), .oDone(oDone),
        .iHSYNC(iHSYNC), .iVSYNC(iVSYNC),
        .iRED(iRED), .iGREEN(iGREEN), .iBLUE(iBLUE),
        .oAddr(oAddr), .oData(oData), .oWrEn(oWrEn)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic logic [17:0] colourOf(input int x, input int y);
        if (x == 0 && y == 0) return {6'h3F, 6'h00, 6'h01};
        if (x == 1 && y == 0) return {6'h00, 6'h3F, 6'h3E};
        return {6'(x * 7 + y), 6'(y * 11 + x * 3), 6'(x + y * 5 + 9)};
    endfunction

    function automatic logic [15:0] pack565(input logic [17:0] c);
        return {c[17:13], c[11:6], c[5:1]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        writes_seen = 0;
        done_seen   = 0;
        first_addr  = '1;
        last_addr   = '1;
        data_a0     = '0;
        data_a1     = '0;
    endtask

    // One clock: check the outputs produced from the pixel driven two clocks
    // ago, then drive the next source pixel.
    task automatic applyStimulus();
        bit          n_in;
        logic [17:0] c;
        @(posedge CLOCK);
        #1;
        if (!RESET) begin
            checkOutput("rst_wren", oWrEn, 0);
            checkOutput("rst_done", oDone, 0);
            checkOutput("rst_addr", oAddr, 0);
            checkOutput("rst_data", oData, 0);
            hold_addr  = '0;
            hold_data  = '0;
            prev_final = 0;
            d1_in      = 0;
        end else begin
            if (!d2_in) checkOutput("wr_outside_window", oWrEn, 0);
            if (oWrEn === 1'b1) begin
                checkOutput("wr_addr", oAddr, d2_addr);
                checkOutput("wr_data", oData, d2_data);
                hold_addr = d2_addr;
                hold_data = d2_data;
                writes_seen++;
                if (writes_seen == 1) first_addr = oAddr;
                last_addr = oAddr;
                if (oAddr == 14'd0) data_a0 = oData;
                if (oAddr == 14'd1) data_a1 = oData;
            end else begin
                checkOutput("hold_addr", oAddr, hold_addr);
                checkOutput("hold_data", oData, hold_data);
            end
            checkOutput("done_after_final", oDone, prev_final);
            if (oDone === 1'b1) done_seen++;
            prev_final = (oWrEn === 1'b1) && (oAddr === FINAL_ADDR);
        end

        n_in = !stall && gh >= HS && gh < HS + XS && gv >= VS && gv < VS + YS;
        iHSYNC = stall ? 1'b1 : (gh >= SA);
        iVSYNC = stall ? 1'b1 : (gv >= SO);
        c = n_in ? colourOf(gh - HS, gv - VS) : 18'($urandom);
        {iRED, iGREEN, iBLUE} = c;
        d2_in   = d1_in;
        d2_addr = d1_addr;
        d2_data = d1_data;
        d1_in   = n_in && RESET;
        d1_addr = 14'(((gv - VS) << 7) + (gh - HS));
        d1_data = pack565(c);
        if (!stall) begin
            gh++;
            if (gh == SE) begin
                gh = 0;
                gv = (gv + 1) % SS;
            end
        end
    endtask

    task automatic runSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic runUntil(input int v, input int h);
        int guard = 0;
        while (!(gv == v && gh == h) && guard < 2 * FRAME) begin
            applyStimulus();
            guard++;
        end
        checkOutput("run_until_reached", (gv == v && gh == h), 1);
    endtask

    initial begin
        RESET = 1'b0; iCall = 1'b0; iHSYNC = 1'b1; iVSYNC = 1'b1;
        iRED = '0; iGREEN = '0; iBLUE = '0;
        clearStats();

        // Reset state, then idle frames with no request
        runSteps(3);
        RESET = 1'b1;
        runSteps(2 * FRAME);
        checkOutput("idle_writes", writes_seen, 0);
        checkOutput("idle_done", done_seen, 0);

        // Request raised mid-window: nothing until the next V edge
        runUntil(8, 0);
        iCall = 1'b1;
        clearStats();
        runUntil(0, 0);
        checkOutput("late_call_writes", writes_seen, 0);

        // Full frame, request dropped partway through capture
        clearStats();
        runUntil(7, 0);
        iCall = 1'b0;
        runUntil(11, 0);
        checkOutput("frame_writes", writes_seen, 32);
        checkOutput("frame_first_addr", first_addr, 0);
        checkOutput("frame_last_addr", last_addr, 391);
        checkOutput("frame_done", done_seen, 1);
        checkOutput("pack_f800", data_a0, 16'hF800);
        checkOutput("pack_07ff", data_a1, 16'h07FF);

        clearStats();
        runSteps(FRAME);
        checkOutput("after_done_writes", writes_seen, 0);
        checkOutput("after_done_done", done_seen, 0);

        // V edge injected mid-capture, request held high across oDone
        iCall = 1'b1;
        clearStats();
        runUntil(7, 15);
        checkOutput("pre_inject_writes", writes_seen, 10);
        checkOutput("pre_inject_done", done_seen, 0);
        gh = 0;
        gv = 0;
        runSteps(2);
        clearStats();
        runUntil(11, 0);
        checkOutput("restart_writes", writes_seen, 32);
        checkOutput("restart_first_addr", first_addr, 0);
        checkOutput("restart_done", done_seen, 1);
        clearStats();
        runSteps(FRAME);
        checkOutput("rearm_writes", writes_seen, 32);
        checkOutput("rearm_done", done_seen, 1);

        // Horizontal sync stalls long enough for CH to saturate
        iCall = 1'b0;
        runUntil(7, 20);
        stall = 1;
        runSteps(2);
        clearStats();
        runSteps(2100);
        checkOutput("stall_writes", writes_seen, 0);
        checkOutput("stall_done", done_seen, 0);
        stall = 0;
        runUntil(11, 0);
        checkOutput("post_stall_writes", writes_seen, 16);
        checkOutput("post_stall_last", last_addr, 391);
        checkOutput("post_stall_done", done_seen, 1);

        // Reset asserted while a write is on the outputs
        iCall = 1'b1;
        runUntil(7, 14);
        checkOutput("pre_reset_wren", oWrEn, 1);
        checkOutput("pre_reset_addr", oAddr, 128);
        RESET = 1'b0;
        #1;
        checkOutput("async_rst_wren", oWrEn, 0);
        checkOutput("async_rst_done", oDone, 0);
        checkOutput("async_rst_addr", oAddr, 0);
        checkOutput("async_rst_data", oData, 0);
        runSteps(3);
        iCall = 1'b0;
        RESET = 1'b1;
        clearStats();
        runSteps(2 * FRAME);
        checkOutput("post_reset_writes", writes_seen, 0);
        checkOutput("post_reset_done", done_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
